// File: rtl/write_demux_if.sv
// rtl/write_demux_if.sv - write-demux handshake bundle: one write stream in, two destination streams out
//
// Signals:
//   in_valid / in_ready / input_data / select : write stream plus destination index
//   out_valid0 / out_ready0 / output_data0    : destination 0 stream
//   out_valid1 / out_ready1 / output_data1    : destination 1 stream
// Modports:
//   slave  : the demux itself (consumes the write stream, produces both destinations)
//   master : the surrounding environment (producer of writes, consumer of both destinations)

interface write_demux_if #(
    parameter int word_size = 5
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [word_size-1:0] input_data;
    logic                 select;

    logic                 out_valid0;
    logic                 out_ready0;
    logic [word_size-1:0] output_data0;

    logic                 out_valid1;
    logic                 out_ready1;
    logic [word_size-1:0] output_data1;

    modport slave (
        input  in_valid, input_data, select, out_ready0, out_ready1,
        output in_ready, out_valid0, output_data0, out_valid1, output_data1
    );

    modport master (
        output in_valid, input_data, select, out_ready0, out_ready1,
        input  in_ready, out_valid0, output_data0, out_valid1, output_data1
    );
endinterface

// File: rtl/write_demux.sv
// rtl/write_demux.sv - steers one write stream into two independent 2-entry FIFOs
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high; discards all buffered words
//   bus          : write_demux_if.slave (write stream in, destinations 0/1 out)
//   xfer_count0  : completed destination 0 pops (only with WRITE_DEMUX_COUNT_EN)
//   xfer_count1  : completed destination 1 pops (only with WRITE_DEMUX_COUNT_EN)
// Parameters:
//   word_size    : data width; must match the interface instance's word_size
//   count_width  : transfer counter width
// Optional feature macro: WRITE_DEMUX_COUNT_EN (adds the transfer counters)

module write_demux #(
    parameter int word_size   = 5,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    write_demux_if.slave           bus
`ifdef WRITE_DEMUX_COUNT_EN
    ,
    output logic [count_width-1:0] xfer_count0,
    output logic [count_width-1:0] xfer_count1
`endif
);

    // Occupancy doubles as the per-destination state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    logic [1:0]                push;
    logic [1:0]                pop;
    logic [1:0]                full;
    logic [1:0]                out_valid;
    logic [1:0]                out_ready;
    logic [1:0][word_size-1:0] head;
    logic                      in_ready;

    assign out_ready[0] = bus.out_ready0;
    assign out_ready[1] = bus.out_ready1;

    // Only the addressed destination can stall the writer; out_ready never
    // reaches in_ready, so a consumer cannot create a combinational loop.
    assign in_ready     = bus.select ? !full[1] : !full[0];
    assign bus.in_ready = in_ready;

    assign bus.out_valid0   = out_valid[0];
    assign bus.output_data0 = head[0];
    assign bus.out_valid1   = out_valid[1];
    assign bus.output_data1 = head[1];

    for (genvar g = 0; g < 2; g++) begin : g_dest
        occ_t                 occ_q;
        occ_t                 occ_d;
        logic [word_size-1:0] mem [2];
        logic                 rd_ptr;
        logic                 wr_ptr;
        logic                 valid;
        logic [word_size-1:0] data_out;

        assign push[g] = bus.in_valid && in_ready && (bus.select == 1'(g));
        assign pop[g]  = valid && out_ready[g];

        // State register
        always_ff @(posedge clk) begin
            if (reset) begin
                occ_q <= EMPTY;
            end else begin
                occ_q <= occ_d;
            end
        end

        // Next-state logic
        always_comb begin
            occ_d = occ_q;
            case (occ_q)
                EMPTY: if (push[g]) occ_d = HALF;
                HALF: begin
                    if (push[g] && !pop[g]) occ_d = FULL;
                    else if (pop[g] && !push[g]) occ_d = EMPTY;
                end
                FULL:  if (pop[g]) occ_d = HALF;
                default: occ_d = EMPTY;
            endcase
        end

        // Output logic: data is forced to zero while empty so stale storage
        // never leaks onto the bus.
        always_comb begin
            valid    = (occ_q != EMPTY);
            data_out = valid ? mem[rd_ptr] : '0;
        end

        // Storage and pointers; both pointers wrap modulo 2 by toggling.
        always_ff @(posedge clk) begin
            if (reset) begin
                mem[0] <= '0;
                mem[1] <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push[g]) begin
                    mem[wr_ptr] <= bus.input_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop[g]) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end

        assign full[g]      = (occ_q == FULL);
        assign out_valid[g] = valid;
        assign head[g]      = data_out;
    end

`ifdef WRITE_DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count0 <= '0;
            xfer_count1 <= '0;
        end else begin
            if (pop[0]) xfer_count0 <= xfer_count0 + count_width'(1);
            if (pop[1]) xfer_count1 <= xfer_count1 + count_width'(1);
        end
    end
`endif

endmodule

// File: tb/tb_write_demux.sv
// tb/tb_write_demux.sv - self-checking bench for write_demux

module tb_write_demux;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    write_demux_if #(.word_size(5)) bus ();

`ifdef WRITE_DEMUX_COUNT_EN
    logic [1:0] xc0;
    logic [1:0] xc1;
`endif

    write_demux #(
        .word_size  (5),
        .count_width(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef WRITE_DEMUX_COUNT_EN
        ,
        .xfer_count0(xc0),
        .xfer_count1(xc1)
`endif
    );

    int checks = 0;
    int fails  = 0;
    logic [4:0] exp0[$];
    logic [4:0] exp1[$];

    // Scoreboard consumer: every accepted pop must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid0 && bus.out_ready0) begin
                checks++;
                if (exp0.size() == 0) begin
                    fails++;
                    $display("FAIL pop0_unexpected: got %h, expected no word", bus.output_data0);
                end else begin
                    logic [4:0] e;
                    e = exp0.pop_front();
                    if (bus.output_data0 !== e) begin
                        fails++;
                        $display("FAIL pop0_data: got %h, expected %h", bus.output_data0, e);
                    end
                end
            end
            if (bus.out_valid1 && bus.out_ready1) begin
                checks++;
                if (exp1.size() == 0) begin
                    fails++;
                    $display("FAIL pop1_unexpected: got %h, expected no word", bus.output_data1);
                end else begin
                    logic [4:0] e;
                    e = exp1.pop_front();
                    if (bus.output_data1 !== e) begin
                        fails++;
                        $display("FAIL pop1_data: got %h, expected %h", bus.output_data1, e);
                    end
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [4:0] d);
        bus.in_valid   = v;
        bus.select     = sel;
        bus.input_data = d;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'h00);
        bus.out_ready0 = 1'b0;
        bus.out_ready1 = 1'b0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid0: got %b, expected 0", bus.out_valid0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin fails++; $display("FAIL reset_out_valid1: got %b, expected 0", bus.out_valid1); end
        checks++; if (bus.output_data0 !== 5'h00) begin fails++; $display("FAIL reset_data0: got %h, expected 00", bus.output_data0); end
        checks++; if (bus.output_data1 !== 5'h00) begin fails++; $display("FAIL reset_data1: got %h, expected 00", bus.output_data1); end
`ifdef WRITE_DEMUX_COUNT_EN
        checks++; if (xc0 !== 2'd0) begin fails++; $display("FAIL reset_count0: got %0d, expected 0", xc0); end
        checks++; if (xc1 !== 2'd0) begin fails++; $display("FAIL reset_count1: got %0d, expected 0", xc1); end
`endif
    endtask

    task automatic test_basic();
        next_cycle();
        bus.out_ready0 = 1'b1;
        bus.out_ready1 = 1'b1;
        drive(1'b1, 1'b0, 5'h03);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready0: got %b, expected 1", bus.in_ready); end
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL basic_no_bypass0: got %b, expected 0", bus.out_valid0); end
        exp0.push_back(5'h03);
        next_cycle();
        drive(1'b1, 1'b1, 5'h1C);
        @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b1) begin fails++; $display("FAIL basic_valid0: got %b, expected 1", bus.out_valid0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin fails++; $display("FAIL basic_no_bypass1: got %b, expected 0", bus.out_valid1); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready1: got %b, expected 1", bus.in_ready); end
        exp1.push_back(5'h1C);
        next_cycle();
        drive(1'b0, 1'b0, 5'h00);
        @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL basic_valid0_one_cycle: got %b, expected 0", bus.out_valid0); end
        checks++; if (bus.out_valid1 !== 1'b1) begin fails++; $display("FAIL basic_valid1: got %b, expected 1", bus.out_valid1); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.out_valid1 !== 1'b0) begin fails++; $display("FAIL basic_valid1_one_cycle: got %b, expected 0", bus.out_valid1); end
`ifdef WRITE_DEMUX_COUNT_EN
        checks++; if (xc0 !== 2'd1) begin fails++; $display("FAIL basic_count0: got %0d, expected 1", xc0); end
        checks++; if (xc1 !== 2'd1) begin fails++; $display("FAIL basic_count1: got %0d, expected 1", xc1); end
`endif
    endtask

    task automatic test_stall();
        next_cycle();
        bus.out_ready0 = 1'b0;
        bus.out_ready1 = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 1'b0, 5'(i));
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stall_accept%0d: got %b, expected 1", i, bus.in_ready); end
            exp0.push_back(5'(i));
            next_cycle();
        end
        drive(1'b1, 1'b0, 5'h03);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_full: got %b, expected 0", bus.in_ready); end
        // A consumer raising ready must not release in_ready in the same cycle.
        #1 bus.out_ready0 = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_no_ready_path: got %b, expected 0", bus.in_ready); end
        bus.out_ready0 = 1'b0;
        next_cycle();
        drive(1'b0, 1'b0, 5'h00);
        next_cycle();
        drive(1'b1, 1'b1, 5'h11);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stall_other_dest: got %b, expected 1", bus.in_ready); end
        checks++; if (bus.output_data0 !== 5'h01) begin fails++; $display("FAIL stall_head0: got %h, expected 01", bus.output_data0); end
        exp1.push_back(5'h11);
        next_cycle();
        drive(1'b0, 1'b0, 5'h00);
        bus.out_ready0 = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL stall_drained: got %b, expected 0", bus.out_valid0); end
        checks++; if (exp0.size() != 0) begin fails++; $display("FAIL stall_pending0: got %0d words left, expected 0", exp0.size()); end
    endtask

    task automatic test_same_cycle();
        next_cycle();
        bus.out_ready1 = 1'b0;
        drive(1'b1, 1'b1, 5'h05);
        @(negedge clk);
        exp1.push_back(5'h05);
        next_cycle();
        drive(1'b1, 1'b1, 5'h06);
        bus.out_ready1 = 1'b1;
        @(negedge clk);
        checks++; if (bus.output_data1 !== 5'h05) begin fails++; $display("FAIL same_head_old: got %h, expected 05", bus.output_data1); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL same_ready: got %b, expected 1", bus.in_ready); end
        exp1.push_back(5'h06);
        next_cycle();
        drive(1'b0, 1'b1, 5'h00);
        bus.out_ready1 = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid1 !== 1'b1) begin fails++; $display("FAIL same_valid: got %b, expected 1", bus.out_valid1); end
        checks++; if (bus.output_data1 !== 5'h06) begin fails++; $display("FAIL same_head_new: got %h, expected 06", bus.output_data1); end
        next_cycle();
        bus.out_ready1 = 1'b1;
        next_cycle();
        @(negedge clk);
        // Occupancy stayed at 1, so a single pop empties the destination.
        checks++; if (bus.out_valid1 !== 1'b0) begin fails++; $display("FAIL same_occ_one: got %b, expected 0", bus.out_valid1); end
    endtask

    task automatic test_reset_flush();
        next_cycle();
        bus.out_ready0 = 1'b0;
        drive(1'b1, 1'b0, 5'h0A);
        next_cycle();
        drive(1'b1, 1'b0, 5'h0B);
        next_cycle();
        drive(1'b0, 1'b0, 5'h00);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL flush_valid0: got %b, expected 0", bus.out_valid0); end
        checks++; if (bus.output_data0 !== 5'h00) begin fails++; $display("FAIL flush_data0: got %h, expected 00", bus.output_data0); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b, expected 1", bus.in_ready); end
`ifdef WRITE_DEMUX_COUNT_EN
        checks++; if (xc0 !== 2'd0) begin fails++; $display("FAIL flush_count0: got %0d, expected 0", xc0); end
`endif
        bus.out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b0) begin fails++; $display("FAIL flush_no_delivery: got %b, expected 0", bus.out_valid0); end
    endtask

`ifdef WRITE_DEMUX_COUNT_EN
    task automatic test_count();
        logic [1:0] want [5];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
        bus.out_ready0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 5'(5'h10 + i));
            @(negedge clk);
            exp0.push_back(5'(5'h10 + i));
            next_cycle();
            drive(1'b0, 1'b0, 5'h00);
            next_cycle();
            @(negedge clk);
            checks++; if (xc0 !== want[i]) begin fails++; $display("FAIL count0_step%0d: got %0d, expected %0d", i, xc0, want[i]); end
        end
        checks++; if (xc1 !== 2'd0) begin fails++; $display("FAIL count1_idle: got %0d, expected 0", xc1); end
    endtask
`endif

    initial begin
        drive(1'b0, 1'b0, 5'h00);
        bus.out_ready0 = 1'b0;
        bus.out_ready1 = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_same_cycle();
        test_reset_flush();
`ifdef WRITE_DEMUX_COUNT_EN
        test_count();
`endif
        next_cycle();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            fails++;
            $display("FAIL undelivered: got %0d/%0d words pending, expected 0/0", exp0.size(), exp1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
